patch_streamer: RTL and testbench
=================================

PATCH_STREAMER -- requirements
Module: patch_streamer

Interface
REQ-001: Parameter K, default 3, is the window edge; a patch holds K*K binary pixels.
REQ-002: Parameter H, default 5, is the image height in rows.
REQ-003: Parameter W, default 5, is the image width in columns.
REQ-004: clk  input  1  is the single clock; all state changes on its rising edge.
REQ-005: rst  input  1  is the reset, asynchronous and active-high.
REQ-006: in_pixel  input  1  carries a binary image pixel in raster order (row-major, column fastest).
REQ-007: in_valid  input  1  marks in_pixel valid.
REQ-008: in_sof  input  1  marks the first pixel of a frame; it is qualified by in_valid.
REQ-009: in_ready  output  1  indicates the block accepts a pixel this cycle.
REQ-010: out_patch  output  K*K  is the flattened window; bit r*K+c holds pixel (row0+r, col0+c), which matches the MAC img bit order.
REQ-011: out_valid  output  1  marks out_patch valid.
REQ-012: out_ready  input  1  indicates the downstream MAC consumes the patch.
REQ-013: out_last  output  1  marks the final patch of a frame, (H-K, W-K).

Function
REQ-014: A pixel is accepted on each cycle where in_valid and in_ready are both 1; in_ready = !out_valid || out_ready (combinational).
REQ-015: Internal counters row (0..H-1) and col (0..W-1) hold the position of the next accepted pixel; col increments per accept and wraps to 0 at W-1, which increments row.
REQ-016: At the accept of pixel (H-1, W-1), row and col wrap to (0,0).
REQ-017: An accepted pixel with in_sof=1 is placed at (0,0) regardless of the counters, and counters continue from (0,1); any partial frame is discarded with no further patches from it.
REQ-018: The block stores the most recent K rows of pixels (K*W bits) in a circular row buffer indexed by row mod K.
REQ-019: Accepting pixel (r,c) with r>=K-1 and c>=K-1 loads out_patch with the window at origin (r-K+1, c-K+1), including the pixel just accepted, and sets out_valid on the next cycle (latency 1).
REQ-020: Accepts at other positions update storage only; out_valid is unaffected by them.
REQ-021: While out_valid=1 and out_ready=0, out_patch and out_last SHALL hold stable and in_ready=0.
REQ-022: out_valid clears after a cycle with out_ready=1, unless the same cycle accepts a pixel that produces a new patch; in that case the new patch loads back-to-back.
REQ-023: out_last=1 only with the patch at origin (H-K, W-K); otherwise it is 0.
REQ-024: Throughput is one pixel per cycle when out_ready is held at 1; a frame produces (H-K+1)*(W-K+1) patches (9 at the defaults).

Reset
REQ-025: While rst=1, asynchronously: row=0, col=0, row buffer cleared to 0, out_valid=0, out_patch=0, out_last=0.
REQ-026: Reset mid-frame discards all buffered pixels and any pending patch; the first pixel after reset is (0,0) whether or not in_sof is set.
REQ-027: in_ready is 1 during and immediately after reset.

Configuration
REQ-028: With macro PATCH_STREAMER_COORD_EN defined, outputs out_row[7:0] and out_col[7:0] give the patch origin and follow the out_patch hold/load rules.
REQ-029: Without PATCH_STREAMER_COORD_EN, those ports and their registers are absent and all other behaviour is identical.

Verification
REQ-030: All-ones 5x5 frame, out_ready=1 -> 9 patches of 9'h1FF on consecutive cycles after pixel (2,2) ... (4,4) excluding col<2; out_last is set on the 9th patch only.
REQ-031: Checkerboard pixel=(r+c)%2==0 -> patch (0,0)=9'h155, patch (0,1)=9'h0AA, patch (1,0)=9'h0AA, patch (1,1)=9'h155.
REQ-032: Hold out_ready=0 when the first patch appears -> in_ready=0, out_patch stable for 10 cycles; on release, the next patch follows with no pixel loss.
REQ-033: Assert rst during pixel (3,1), then stream a fresh all-zero frame -> out_valid drops at once, and exactly 9 patches of 9'h000 follow.
REQ-034: in_sof asserted at (2,4) of a partial frame -> the partial frame yields no further patches; the restarted frame yields exactly 9 patches with correct contents.
REQ-035: With PATCH_STREAMER_COORD_EN defined -> out_row/out_col sequence (0,0),(0,1),(0,2),(1,0)...(2,2).

Source files
------------

// File: rtl/patch_streamer.sv
// Slides a KxK window over a raster-order binary image, one pixel per cycle.
// Define PATCH_STREAMER_COORD_EN to add out_row/out_col patch origin outputs.
module patch_streamer #(
   parameter int K = 3,
   parameter int H = 5,
   parameter int W = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_pixel,
   input  logic           in_valid,
   input  logic           in_sof,
   output logic           in_ready,
   output logic [K*K-1:0] out_patch,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_last
`ifdef PATCH_STREAMER_COORD_EN
   ,
   output logic [7:0]     out_row,
   output logic [7:0]     out_col
`endif
);

   localparam int RW = $clog2(H > 1 ? H : 2);
   localparam int CW = $clog2(W > 1 ? W : 2);
   localparam int SW = $clog2(K > 1 ? K : 2);

   logic [RW-1:0] row, r_eff, row_nx;
   logic [CW-1:0] col, c_eff, col_nx;
   logic [SW-1:0] slot, s_eff, slot_nx;
   logic [W-1:0]  rbuf [K];
   logic [W-1:0]  cur_row, rowv, seg;
   logic [K*K-1:0] win;
   logic          accept, hit, last_hit;
   int            t;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      r_eff = in_sof ? '0 : row;
      c_eff = in_sof ? '0 : col;
      s_eff = in_sof ? '0 : slot;
      cur_row = rbuf[s_eff];
      cur_row[c_eff] = in_pixel;
      hit = (r_eff >= RW'(K-1)) && (c_eff >= CW'(K-1));
      last_hit = (r_eff == RW'(H-1)) && (c_eff == CW'(W-1));
      // Oldest window row sits in the slot just after the current one.
      win = '0;
      rowv = '0;
      seg = '0;
      t = 0;
      for (int i = 0; i < K; i++) begin
         t = int'(s_eff) + 1 + i;
         if (t >= K) t = t - K;
         rowv = (i == K-1) ? cur_row : rbuf[SW'(t)];
         seg = rowv >> (c_eff - CW'(K-1));
         win[i*K +: K] = seg[K-1:0];
      end
      col_nx = c_eff + 1'b1;
      row_nx = r_eff;
      slot_nx = s_eff;
      if (c_eff == CW'(W-1)) begin
         col_nx = '0;
         if (r_eff == RW'(H-1)) begin
            row_nx = '0;
            slot_nx = '0;
         end else begin
            row_nx = r_eff + 1'b1;
            slot_nx = (s_eff == SW'(K-1)) ? '0 : s_eff + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row <= '0;
         col <= '0;
         slot <= '0;
         for (int i = 0; i < K; i++) rbuf[i] <= '0;
      end else if (accept) begin
         row <= row_nx;
         col <= col_nx;
         slot <= slot_nx;
         rbuf[s_eff] <= cur_row;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_patch <= '0;
         out_last <= 1'b0;
      end else if (accept && hit) begin
         out_valid <= 1'b1;
         out_patch <= win;
         out_last <= last_hit;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef PATCH_STREAMER_COORD_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_row <= '0;
         out_col <= '0;
      end else if (accept && hit) begin
         out_row <= 8'(r_eff) - 8'(K-1);
         out_col <= 8'(c_eff) - 8'(K-1);
      end
   end
`endif

endmodule

// File: tb/tb_patch_streamer.sv
// Bench for patch_streamer: image-model scoreboard plus table of known patches.
module tb_patch_streamer;
   localparam int K = 3;
   localparam int H = 5;
   localparam int W = 5;

   logic clk = 1'b0;
   logic rst, in_pixel, in_valid, in_sof, in_ready;
   logic out_valid, out_ready, out_last;
   logic [K*K-1:0] out_patch;
`ifdef PATCH_STREAMER_COORD_EN
   logic [7:0] out_row, out_col;
`endif

   always #5 clk = ~clk;

   patch_streamer #(.K(K), .H(H), .W(W)) dut (
      .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
      .in_sof(in_sof), .in_ready(in_ready), .out_patch(out_patch),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef PATCH_STREAMER_COORD_EN
      , .out_row(out_row), .out_col(out_col)
`endif
   );

   typedef struct {
      logic [8:0] patch;
      logic       last;
      int         orow;
      int         ocol;
   } exp_t;

   typedef struct {
      int         frame;
      int         idx;
      logic [8:0] patch;
      logic       last;
   } vec_t;

   exp_t sbq[$];
   exp_t log_q[$];
   exp_t e;
   logic [8:0] p;
   logic img [H][W];
   int mr = 0, mc = 0;
   int n_checks = 0, n_fail = 0, n_out = 0, stalls = 0;
   logic [8:0] lp [2][9];
   logic ll [2][9];
   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: model the raster image, predict each patch on accept.
   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
         mr = 0;
         mc = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_patch: got %0h expected none", out_patch);
            end else begin
               e = sbq.pop_front();
               chk("patch", 32'(out_patch), 32'(e.patch));
               chk("last", 32'(out_last), 32'(e.last));
`ifdef PATCH_STREAMER_COORD_EN
               chk("out_row", 32'(out_row), e.orow);
               chk("out_col", 32'(out_col), e.ocol);
`endif
               log_q.push_back('{out_patch, out_last, e.orow, e.ocol});
               n_out++;
            end
         end
         if (in_valid && in_ready) begin
            if (in_sof) begin
               mr = 0;
               mc = 0;
            end
            img[mr][mc] = in_pixel;
            if (mr >= K-1 && mc >= K-1) begin
               for (int i = 0; i < K; i++)
                  for (int j = 0; j < K; j++)
                     p[i*K+j] = img[mr-K+1+i][mc-K+1+j];
               sbq.push_back('{p, (mr == H-1 && mc == W-1), mr-K+1, mc-K+1});
            end
            mc++;
            if (mc == W) begin
               mc = 0;
               mr++;
               if (mr == H) mr = 0;
            end
         end
      end
   end

   function automatic logic pix(input int kind, input int r, input int c);
      case (kind)
         0: return 1'b0;
         1: return 1'b1;
         2: return ((r + c) % 2) == 0;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic send_px(input logic v, input logic s);
      int waitc;
      waitc = 0;
      in_valid = 1'b1;
      in_pixel = v;
      in_sof = s;
      @(negedge clk);
      while (!in_ready && waitc < 100) begin
         waitc++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
      end
      stalls += waitc;
      @(posedge clk);
      #1;
   endtask

   task automatic send_range(input int kind, input int first, input int last,
                             input logic sof_first);
      for (int n = first; n <= last; n++)
         send_px(pix(kind, n / W, n % W), (n == first) && sof_first);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_sof = 1'b0;
      in_pixel = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      idle();
      out_ready = 1'b1;
      while ((sbq.size() != 0 || out_valid) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", 32'(sbq.size()), 0);
      chk("drain_valid", 32'(out_valid), 0);
   endtask

   task automatic save_log(input int f);
      for (int k = 0; k < 9; k++) begin
         lp[f][k] = (k < log_q.size()) ? log_q[k].patch : 'x;
         ll[f][k] = (k < log_q.size()) ? log_q[k].last : 1'bx;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      logic [8:0] held;
      logic nxt;

      for (int k = 0; k < 9; k++)
         tbl[k] = '{0, k, 9'h1FF, (k == 8)};
      tbl[0] = '{0, 0, 9'h1FF, 1'b0};
      tbl[1] = '{1, 0, 9'h155, 1'b0};
      tbl[2] = '{1, 1, 9'h0AA, 1'b0};
      tbl[3] = '{1, 2, 9'h155, 1'b0};
      tbl[4] = '{1, 3, 9'h0AA, 1'b0};
      tbl[5] = '{1, 4, 9'h155, 1'b0};
      tbl[6] = '{0, 8, 9'h1FF, 1'b1};
      tbl[7] = '{0, 7, 9'h1FF, 1'b0};
      tbl[8] = '{1, 8, 9'h155, 1'b1};

      rst = 1'b1;
      out_ready = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_patch", 32'(out_patch), 0);
      chk("rst_last", 32'(out_last), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 1);

      // All-ones frame at full rate.
      n0 = n_out;
      stalls = 0;
      log_q.delete();
      send_range(1, 0, H*W-1, 1'b1);
      drain();
      chk("ones_count", 32'(n_out - n0), 9);
      chk("ones_stalls", 32'(stalls), 0);
      save_log(0);

      // Checkerboard frame.
      n0 = n_out;
      log_q.delete();
      send_range(2, 0, H*W-1, 1'b1);
      drain();
      chk("chk_count", 32'(n_out - n0), 9);
      save_log(1);

      for (int k = 0; k < 9; k++) begin
         chk("tbl_patch", 32'(lp[tbl[k].frame][tbl[k].idx]), 32'(tbl[k].patch));
         chk("tbl_last", 32'(ll[tbl[k].frame][tbl[k].idx]), 32'(tbl[k].last));
      end

      // Back-pressure on the first patch.
      n0 = n_out;
      out_ready = 1'b0;
      send_range(3, 0, 2*W+2, 1'b1);
      chk("bp_valid", 32'(out_valid), 1);
      held = out_patch;
      nxt = pix(3, 0, 0);
      in_valid = 1'b1;
      in_pixel = nxt;
      in_sof = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_hold", 32'(out_patch), 32'(held));
         chk("bp_valid_hold", 32'(out_valid), 1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send_px(nxt, 1'b0);
      send_range(3, 2*W+4, H*W-1, 1'b0);
      drain();
      chk("bp_count", 32'(n_out - n0), 9);

      // Reset in the middle of pixel (3,1).
      send_range(1, 0, 3*W, 1'b1);
      in_valid = 1'b1;
      in_pixel = 1'b1;
      in_sof = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_patch", 32'(out_patch), 0);
      chk("mid_rst_in_ready", 32'(in_ready), 1);
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n0 = n_out;
      log_q.delete();
      send_range(0, 0, H*W-1, 1'b0);
      drain();
      chk("rst_frame_count", 32'(n_out - n0), 9);
      for (int k = 0; k < log_q.size(); k++)
         chk("rst_frame_zero", 32'(log_q[k].patch), 0);

      // Frame restart by in_sof at (2,4).
      n0 = n_out;
      send_range(3, 0, 2*W+3, 1'b1);
      send_range(3, 0, H*W-1, 1'b1);
      drain();
      chk("sof_count", 32'(n_out - n0), 11);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
